regfile_scoreboard: RTL
=======================

Name:
regfile_scoreboard

Overview:
- Hazard scoreboard that sequences access to the 8-entry LC-3b register file in the pipeline.
- Tracks in-flight writes per architectural register.
- Stalls decode on RAW hazards (source register pending) and on counter saturation for the destination.
- Sits beside decode; retire and kill notifications arrive from writeback and from the flush logic.

Parameters:
- NUM_REGS, 8, number of architectural registers; index width fixed at 3 bits.
- CNT_W, 2, width of each per-register pending-write counter; maximum count CMAX = 2^CNT_W - 1.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- dec_valid  input  1  decode holds a valid instruction.
- dec_sr1  input  3  source register 1 index.
- dec_sr1_used  input  1  instruction reads sr1.
- dec_sr2  input  3  source register 2 index.
- dec_sr2_used  input  1  instruction reads sr2.
- dec_dr  input  3  destination register index.
- dec_dr_used  input  1  instruction writes dr.
- dec_stall  output  1  combinational; hold decode this cycle.
- issue  output  1  combinational; dec_valid & ~dec_stall.
- wb_valid  input  1  writeback retires one write to wb_dr this cycle (same cycle as regfile we).
- wb_dr  input  3  register retired by writeback.
- kill_valid  input  1  an in-flight writer of kill_dr was squashed; it will never write back.
- kill_dr  input  3  register whose pending write is cancelled.
- busy_vec  output  NUM_REGS  registered; bit r = (cnt[r] != 0).
- err  output  1  registered, sticky; set on an illegal decrement.

Behaviour:
- State: cnt[0..NUM_REGS-1], each CNT_W bits, plus the err flag.
- Reset (rst=1 at posedge): all cnt = 0, busy_vec = 0, err = 0.
  - rst overrides all same-cycle inc/dec.
  - Instructions in flight at reset are forgotten.
- hazard1 = dec_sr1_used & (cnt[dec_sr1] != 0).
- hazard2 = dec_sr2_used & (cnt[dec_sr2] != 0).
- sat = dec_dr_used & (cnt[dec_dr] == CMAX).
- dec_stall = dec_valid & (hazard1 | hazard2 | sat).
  - Computed from current registered counts only.
  - No same-cycle bypass: a source retiring by wb this cycle still stalls; it clears the next cycle.
  - The register file has no write-to-read forwarding, so this rule is required.
- During rst, dec_stall still follows current counts; counts are 0 after the reset edge.
- inc[r] = issue & dec_dr_used & (dec_dr == r).
- dec[r] = (wb_valid & wb_dr == r) + (kill_valid & kill_dr == r); range 0..2.
- Next count, per register: cnt[r] + inc[r] - dec[r].
  - Simultaneous inc and dec on the same register net out in one cycle; e.g. cnt=1 with inc=1 and dec=1 gives 1.
  - Underflow (cnt + inc < dec): count clamps to 0 and err is set.
  - Overflow cannot occur, because sat blocks issue at CMAX; a dec in the same cycle does not unblock it.
- busy_vec and err update at the same edge as the counts.
  - Latency: issue at cycle N gives busy at N+1; the final retire at cycle N clears busy at N+1.
- Registers r >= NUM_REGS never exist; indices are always 3 bits.
- Once set, err stays set until rst.

Test Plan:
- Reset then idle: rst for 2 cycles, then dec_valid=1, sr1=R3 used → dec_stall=0, issue=1, busy_vec=8'h00, err=0.
- Basic RAW: cycle 0 issue dr=R2; cycle 1 sr1=R2 used → dec_stall=1, busy_vec=8'h04; cycle 3 wb_valid, wb_dr=R2 → stall stays 1 in cycle 3, becomes 0 in cycle 4, busy_vec=8'h00.
- Simultaneous inc/dec: cnt[R5]=1; issue dr=R5 in the same cycle as wb_dr=R5 → cnt[R5]=1 next cycle, busy_vec bit5=1; a second wb → bit5=0.
- Saturation (CNT_W=2): issue three writers of R1 → cnt=3; a fourth with dr=R1 → dec_stall=1; one wb of R1 → cnt=2, fourth issues the following cycle.
- Kill plus wb on the same register: cnt[R7]=2, wb_dr=R7 and kill_dr=R7 together → cnt=0, err=0. Then a lone wb_dr=R7 → err=1 and stays set; rst → err=0.
- Reset mid-operation: cnt[R0]=2, cnt[R4]=1, rst asserted together with an issue of dr=R4 → all counts 0, busy_vec=8'h00 after the edge.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
// Hazard scoreboard for the 8-entry LC-3b register file. One small
// pending-write counter per architectural register. Decode is stalled when a
// source is still being written (RAW) or when the destination counter is
// already full. Writeback retirements and flush kills both decrement.
// ---------------------------------------------------------------------------
module regfile_scoreboard #(
    parameter int NUM_REGS = 8,
    parameter int CNT_W    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                dec_valid,
    input  logic [2:0]          dec_sr1,
    input  logic                dec_sr1_used,
    input  logic [2:0]          dec_sr2,
    input  logic                dec_sr2_used,
    input  logic [2:0]          dec_dr,
    input  logic                dec_dr_used,
    output logic                dec_stall,
    output logic                issue,
    input  logic                wb_valid,
    input  logic [2:0]          wb_dr,
    input  logic                kill_valid,
    input  logic [2:0]          kill_dr,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic                err
);

    localparam logic [CNT_W-1:0] CMAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CZERO = {CNT_W{1'b0}};

    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic                err_q;
    logic                err_d;

    logic                hazard1_s;
    logic                hazard2_s;
    logic                sat_s;
    logic                stall_s;
    logic                issue_s;
    logic                underflow_s;

    // Hazard detection from the registered counts only; no same-cycle
    // bypass of a retiring writer because the regfile does not forward.
    always_comb begin
        hazard1_s = dec_sr1_used & (cnt_q[dec_sr1] != CZERO);
        hazard2_s = dec_sr2_used & (cnt_q[dec_sr2] != CZERO);
        sat_s     = dec_dr_used  & (cnt_q[dec_dr]  == CMAX);
        stall_s   = dec_valid & (hazard1_s | hazard2_s | sat_s);
        issue_s   = dec_valid & ~stall_s;
    end

    assign dec_stall = stall_s;
    assign issue     = issue_s;
    assign busy_vec  = busy_q;
    assign err       = err_q;

    // Next-state counts: add the issuing writer, subtract retire and kill,
    // clamp to zero and flag an error if more writes leave than exist.
    always_comb begin
        underflow_s = 1'b0;
        busy_d      = {NUM_REGS{1'b0}};
        for (int r = 0; r < NUM_REGS; r++) begin
            logic             inc_hit;
            logic             wb_hit;
            logic             kill_hit;
            logic [CNT_W:0]   up_ext;
            logic [CNT_W:0]   dn_ext;
            logic [CNT_W:0]   diff_ext;
            inc_hit  = issue_s & dec_dr_used & (dec_dr == 3'(r));
            wb_hit   = wb_valid & (wb_dr == 3'(r));
            kill_hit = kill_valid & (kill_dr == 3'(r));
            up_ext   = {1'b0, cnt_q[r]} + {{CNT_W{1'b0}}, inc_hit};
            dn_ext   = {{CNT_W{1'b0}}, wb_hit} + {{CNT_W{1'b0}}, kill_hit};
            diff_ext = up_ext - dn_ext;
            if (up_ext < dn_ext) begin
                cnt_d[r]    = CZERO;
                underflow_s = 1'b1;
            end else begin
                cnt_d[r] = diff_ext[CNT_W-1:0];
            end
            busy_d[r] = (cnt_d[r] != CZERO);
        end
        err_d = err_q | underflow_s;
    end

    // State register; reset wins over any same-cycle increment or decrement.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= CZERO;
            end
            busy_q <= {NUM_REGS{1'b0}};
            err_q  <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

endmodule
